// File: rtl/unsigned_multiply_arbiter.sv
// Round-robin arbiter sharing one registered unsigned multiplier among NREQ
// requesters; tagged results are buffered in a 4-entry in-order FIFO.

module unsigned_multiply #(
  parameter int unsigned AWIDTH = 16,
  parameter int unsigned BWIDTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [AWIDTH-1:0]        i_a,
  input  logic [BWIDTH-1:0]        i_b,
  output logic [AWIDTH+BWIDTH-1:0] o_p
);
  localparam int unsigned OUTWID = AWIDTH + BWIDTH;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_p <= '0;
    end else begin
      o_p <= OUTWID'(i_a) * OUTWID'(i_b);
    end
  end
endmodule

module unsigned_multiply_arbiter #(
  parameter int unsigned AWIDTH = 16,
  parameter int unsigned BWIDTH = 16,
  parameter int unsigned NREQ   = 4
) (
  input  logic                                          i_clk,
  input  logic                                          i_rst_n,
  input  logic [NREQ-1:0]                               i_req_valid,
  output logic [NREQ-1:0]                               o_req_ready,
  input  logic [NREQ*AWIDTH-1:0]                        i_a,
  input  logic [NREQ*BWIDTH-1:0]                        i_b,
  output logic                                          o_prod_valid,
  input  logic                                          i_prod_ready,
  output logic [AWIDTH+BWIDTH-1:0]                      o_prod,
  output logic [((NREQ <= 2) ? 1 : $clog2(NREQ))-1:0]   o_prod_id,
  output logic                                          o_busy
);
  localparam int unsigned IDW    = (NREQ <= 2) ? 1 : $clog2(NREQ);
  localparam int unsigned OUTWID = AWIDTH + BWIDTH;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PW     = 2;
  localparam int unsigned CW     = 3;

  logic [IDW-1:0]    r_last;
  logic [IDW-1:0]    w_cand;
  logic              w_found;
  logic [AWIDTH-1:0] w_a_sel;
  logic [BWIDTH-1:0] w_b_sel;
  logic [3:0]        w_outstanding;
  logic              w_pop;
  logic              w_credit_ok;
  logic              w_xfer;

  logic              r_s0_valid;
  logic [AWIDTH-1:0] r_s0_a;
  logic [BWIDTH-1:0] r_s0_b;
  logic [IDW-1:0]    r_s0_id;
  logic              r_s1_valid;
  logic [IDW-1:0]    r_s1_id;
  logic [OUTWID-1:0] w_s1_prod;

  logic [OUTWID-1:0] r_fifo_prod [DEPTH];
  logic [IDW-1:0]    r_fifo_id   [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;

  // Round-robin search starting just after the last granted index.
  always_comb begin
    int unsigned idx;
    w_found = 1'b0;
    w_cand  = '0;
    idx     = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = (32'(r_last) + i) % NREQ;
      if (!w_found && i_req_valid[IDW'(idx)]) begin
        w_found = 1'b1;
        w_cand  = IDW'(idx);
      end
    end
  end

  always_comb begin
    w_a_sel = '0;
    w_b_sel = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (w_cand == IDW'(k)) begin
        w_a_sel = i_a[k*AWIDTH +: AWIDTH];
        w_b_sel = i_b[k*BWIDTH +: BWIDTH];
      end
    end
  end

  // Credit counts the pop in the same cycle so a full pipeline can still grant.
  assign w_outstanding = 4'(r_s0_valid) + 4'(r_s1_valid) + 4'(r_count);
  assign w_pop         = o_prod_valid & i_prod_ready;
  assign w_credit_ok   = (w_outstanding - 4'(w_pop)) < 4'd4;
  assign o_req_ready   = (w_found && w_credit_ok && i_rst_n) ? (NREQ'(1) << w_cand) : '0;
  assign w_xfer        = |(i_req_valid & o_req_ready);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last     <= IDW'(NREQ - 1);
      r_s0_valid <= 1'b0;
      r_s0_a     <= '0;
      r_s0_b     <= '0;
      r_s0_id    <= '0;
      r_s1_valid <= 1'b0;
      r_s1_id    <= '0;
    end else begin
      r_s0_valid <= w_xfer;
      r_s1_valid <= r_s0_valid;
      r_s1_id    <= r_s0_id;
      if (w_xfer) begin
        r_s0_a  <= w_a_sel;
        r_s0_b  <= w_b_sel;
        r_s0_id <= w_cand;
        r_last  <= w_cand;
      end
    end
  end

  unsigned_multiply #(
    .AWIDTH (AWIDTH),
    .BWIDTH (BWIDTH)
  ) u_mul (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_a     (r_s0_a),
    .i_b     (r_s0_b),
    .o_p     (w_s1_prod)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (r_s1_valid) r_wptr <= r_wptr + PW'(1);
      if (w_pop)      r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(r_s1_valid) - CW'(w_pop);
    end
  end

  // Storage needs no reset: the head is only exposed while r_count is nonzero.
  always_ff @(posedge i_clk) begin
    if (r_s1_valid) begin
      r_fifo_prod[r_wptr] <= w_s1_prod;
      r_fifo_id[r_wptr]   <= r_s1_id;
    end
  end

  assign o_prod_valid = (r_count != '0);
  assign o_prod       = o_prod_valid ? r_fifo_prod[r_rptr] : '0;
  assign o_prod_id    = o_prod_valid ? r_fifo_id[r_rptr] : '0;
  assign o_busy       = r_s0_valid | r_s1_valid | (r_count != '0);

endmodule
